// File: rtl/ps2_key_decoder_if.sv
// rtl/ps2_key_decoder_if.sv - scan byte input and key event output handshake bundle
interface ps2_key_decoder_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_ascii;
  logic [7:0] out_scan;
  logic       out_ext;
  logic       out_repeat;

  modport master (
    output in_data, in_valid, out_ready,
    input  out_valid, out_ascii, out_scan, out_ext, out_repeat
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output out_valid, out_ascii, out_scan, out_ext, out_repeat
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 set-2 scan code parser with modifier tracking and key event FIFO
module ps2_key_decoder #(
  parameter int FIFO_DEPTH    = 8,
  parameter int CNT_W         = 8,
  parameter int REPEAT_FILTER = 1
) (
  input  logic                        clk,
  input  logic                        clrn,
  ps2_key_decoder_if.slave            bus,
  output logic                        shift_flag,
  output logic                        ctrl_flag,
  output logic                        caps_flag,
  output logic [CNT_W-1:0]            key_count,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  typedef struct packed {
    logic       rep;
    logic       ext;
    logic [7:0] scan;
    logic [7:0] ascii;
  } event_t;

  state_t           state_q, state_d;
  logic [3:0]       mods_q, mods_d;          // {rctrl, lctrl, rshift, lshift}
  logic             caps_q, caps_d;
  logic             caps_held_q, caps_held_d;
  logic             held_valid_q, held_valid_d;
  logic [8:0]       held_q, held_d;          // {ext, code} of last non-modifier press
  logic [CNT_W-1:0] count_q, count_d;
  logic             evt_valid_q, evt_valid_d;
  event_t           evt_q, evt_d;
  event_t           mem_q [FIFO_DEPTH];
  event_t           mem_d [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             ovf_q, ovf_d;

  logic       is_make, is_brk, ev_ext;
  logic [7:0] ev_code, ev_ascii;
  logic       k_lshift, k_rshift, k_lctrl, k_rctrl, k_caps, k_fake, k_mod, same_key;
  logic       push, pop, full, do_push;

  function automatic logic [7:0] to_ascii(input logic [7:0] code, input logic shift,
                                          input logic caps);
    logic [7:0] r;
    r = 8'h00;
    case (code)
      8'h1C: r = "a";  8'h32: r = "b";  8'h21: r = "c";  8'h23: r = "d";
      8'h24: r = "e";  8'h2B: r = "f";  8'h34: r = "g";  8'h33: r = "h";
      8'h43: r = "i";  8'h3B: r = "j";  8'h42: r = "k";  8'h4B: r = "l";
      8'h3A: r = "m";  8'h31: r = "n";  8'h44: r = "o";  8'h4D: r = "p";
      8'h15: r = "q";  8'h2D: r = "r";  8'h1B: r = "s";  8'h2C: r = "t";
      8'h3C: r = "u";  8'h2A: r = "v";  8'h1D: r = "w";  8'h22: r = "x";
      8'h35: r = "y";  8'h1A: r = "z";
      8'h16: r = shift ? "!" : "1";
      8'h1E: r = shift ? "@" : "2";
      8'h26: r = shift ? "#" : "3";
      8'h25: r = shift ? "$" : "4";
      8'h2E: r = shift ? "%" : "5";
      8'h36: r = shift ? "^" : "6";
      8'h3D: r = shift ? "&" : "7";
      8'h3E: r = shift ? "*" : "8";
      8'h46: r = shift ? "(" : "9";
      8'h45: r = shift ? ")" : "0";
      8'h29: r = 8'h20;
      8'h5A: r = 8'h0D;
      8'h66: r = 8'h08;
      default: r = 8'h00;
    endcase
    // Only letters react to caps; digit rows above were already resolved by shift alone.
    if (r >= "a" && r <= "z" && (shift ^ caps)) r = r - 8'h20;
    return r;
  endfunction

  always_comb begin
    state_d      = state_q;
    mods_d       = mods_q;
    caps_d       = caps_q;
    caps_held_d  = caps_held_q;
    held_valid_d = held_valid_q;
    held_d       = held_q;
    count_d      = count_q;
    evt_valid_d  = 1'b0;
    evt_d        = evt_q;
    is_make      = 1'b0;
    is_brk       = 1'b0;
    ev_ext       = 1'b0;
    ev_code      = bus.in_data;

    if (bus.in_valid) begin
      case (state_q)
        IDLE: begin
          if (bus.in_data == 8'hE0)      state_d = EXT;
          else if (bus.in_data == 8'hF0) state_d = BRK;
          else                           is_make = 1'b1;
        end
        EXT: begin
          if (bus.in_data == 8'hF0) state_d = EXT_BRK;
          else begin
            is_make = 1'b1;
            ev_ext  = 1'b1;
            state_d = IDLE;
          end
        end
        BRK: begin
          is_brk  = 1'b1;
          state_d = IDLE;
        end
        default: begin
          is_brk  = 1'b1;
          ev_ext  = 1'b1;
          state_d = IDLE;
        end
      endcase
    end

    k_lshift = !ev_ext && ev_code == 8'h12;
    k_rshift = !ev_ext && ev_code == 8'h59;
    k_lctrl  = !ev_ext && ev_code == 8'h14;
    k_rctrl  =  ev_ext && ev_code == 8'h14;
    k_caps   = !ev_ext && ev_code == 8'h58;
    k_fake   =  ev_ext && (ev_code == 8'h12 || ev_code == 8'h59);
    k_mod    = k_lshift | k_rshift | k_lctrl | k_rctrl | k_caps | k_fake;
    same_key = held_valid_q && held_q == {ev_ext, ev_code};
    ev_ascii = ev_ext ? 8'h00 : to_ascii(ev_code, |mods_q[1:0], caps_q);

    if (is_make || is_brk) begin
      if (k_mod) begin
        if (k_lshift) mods_d[0] = is_make;
        if (k_rshift) mods_d[1] = is_make;
        if (k_lctrl)  mods_d[2] = is_make;
        if (k_rctrl)  mods_d[3] = is_make;
        if (k_caps) begin
          if (is_make && !caps_held_q) caps_d = !caps_q;
          caps_held_d = is_make;
        end
      end else if (is_make) begin
        if (same_key) begin
          if (REPEAT_FILTER == 0) begin
            evt_valid_d = 1'b1;
            evt_d       = {1'b1, ev_ext, ev_code, ev_ascii};
          end
        end else begin
          held_valid_d = 1'b1;
          held_d       = {ev_ext, ev_code};
          count_d      = count_q + CNT_W'(1);
          evt_valid_d  = 1'b1;
          evt_d        = {1'b0, ev_ext, ev_code, ev_ascii};
        end
      end else if (same_key) begin
        held_valid_d = 1'b0;
      end
    end
  end

  // Events are staged one cycle in evt_q, so the FIFO push happens on the edge after acceptance.
  always_comb begin
    push     = evt_valid_q;
    pop      = (level_q != '0) && bus.out_ready;
    full     = level_q == (AW+1)'(FIFO_DEPTH);
    do_push  = push && (!full || pop);
    ovf_d    = ovf_q | (push && full && !pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = evt_q;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !pop)      level_d = level_q + (AW+1)'(1);
    else if (!do_push && pop) level_d = level_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (clrn) begin
      state_q      <= IDLE;
      mods_q       <= '0;
      caps_q       <= 1'b0;
      caps_held_q  <= 1'b0;
      held_valid_q <= 1'b0;
      held_q       <= '0;
      count_q      <= '0;
      evt_valid_q  <= 1'b0;
      evt_q        <= '0;
      mem_q        <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      mods_q       <= mods_d;
      caps_q       <= caps_d;
      caps_held_q  <= caps_held_d;
      held_valid_q <= held_valid_d;
      held_q       <= held_d;
      count_q      <= count_d;
      evt_valid_q  <= evt_valid_d;
      evt_q        <= evt_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      ovf_q        <= ovf_d;
    end
  end

  assign bus.out_valid  = level_q != '0;
  assign bus.out_ascii  = mem_q[rd_ptr_q].ascii;
  assign bus.out_scan   = mem_q[rd_ptr_q].scan;
  assign bus.out_ext    = mem_q[rd_ptr_q].ext;
  assign bus.out_repeat = mem_q[rd_ptr_q].rep;
  assign shift_flag     = |mods_q[1:0];
  assign ctrl_flag      = |mods_q[3:2];
  assign caps_flag      = caps_q;
  assign key_count      = count_q;
  assign fifo_level     = level_q;
  assign overflow       = ovf_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - directed vector bench for ps2_key_decoder (filtered and unfiltered repeats)
module tb_ps2_key_decoder;

  logic clk = 1'b0;
  logic clrn;
  always #5 clk = ~clk;

  ps2_key_decoder_if bus1 ();
  ps2_key_decoder_if bus2 ();

  logic       shift1, ctrl1, caps1, ovf1, shift2, ctrl2, caps2, ovf2;
  logic [7:0] cnt1, cnt2;
  logic [3:0] lvl1, lvl2;

  ps2_key_decoder #(.FIFO_DEPTH(8), .CNT_W(8), .REPEAT_FILTER(1)) dut1 (
    .clk(clk), .clrn(clrn), .bus(bus1),
    .shift_flag(shift1), .ctrl_flag(ctrl1), .caps_flag(caps1),
    .key_count(cnt1), .fifo_level(lvl1), .overflow(ovf1)
  );

  ps2_key_decoder #(.FIFO_DEPTH(8), .CNT_W(8), .REPEAT_FILTER(0)) dut2 (
    .clk(clk), .clrn(clrn), .bus(bus2),
    .shift_flag(shift2), .ctrl_flag(ctrl2), .caps_flag(caps2),
    .key_count(cnt2), .fifo_level(lvl2), .overflow(ovf2)
  );

  typedef struct {
    logic [7:0] data;
    logic       shift;
    logic       ctrl;
    logic       caps;
    int         count;
    logic       ev;
    logic [7:0] ascii;
    logic       ext;
  } vec_t;

  vec_t vecs[$];
  int   tests  = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus1.in_data  = b;
    bus2.in_data  = b;
    bus1.in_valid = 1'b1;
    bus2.in_valid = 1'b1;
    tick();
    bus1.in_valid = 1'b0;
    bus2.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    clrn = 1'b1;
    tick();
    clrn = 1'b0;
  endtask

  task automatic pop1();
    bus1.out_ready = 1'b1;
    tick();
    bus1.out_ready = 1'b0;
  endtask

  task automatic pop2();
    bus2.out_ready = 1'b1;
    tick();
    bus2.out_ready = 1'b0;
  endtask

  task automatic add(input logic [7:0] d, input logic s, input logic c, input logic k,
                     input int n, input logic ev = 1'b0, input logic [7:0] a = 8'h00,
                     input logic x = 1'b0);
    vec_t v;
    v.data = d; v.shift = s; v.ctrl = c; v.caps = k; v.count = n;
    v.ev = ev; v.ascii = a; v.ext = x;
    vecs.push_back(v);
  endtask

  logic [7:0] ovf_codes [10];

  initial begin
    add(8'h1C, 0, 0, 0, 1, 1, 8'h61);
    add(8'hF0, 0, 0, 0, 1); add(8'h1C, 0, 0, 0, 1);
    add(8'h12, 1, 0, 0, 1);
    add(8'h1C, 1, 0, 0, 2, 1, 8'h41);
    add(8'hF0, 1, 0, 0, 2); add(8'h1C, 1, 0, 0, 2);
    add(8'hF0, 1, 0, 0, 2); add(8'h12, 0, 0, 0, 2);
    add(8'h58, 0, 0, 1, 2); add(8'hF0, 0, 0, 1, 2); add(8'h58, 0, 0, 1, 2);
    add(8'h1C, 0, 0, 1, 3, 1, 8'h41);
    add(8'hF0, 0, 0, 1, 3); add(8'h1C, 0, 0, 1, 3);
    add(8'h58, 0, 0, 0, 3); add(8'hF0, 0, 0, 0, 3); add(8'h58, 0, 0, 0, 3);
    add(8'h58, 0, 0, 1, 3); add(8'h58, 0, 0, 1, 3);
    add(8'hF0, 0, 0, 1, 3); add(8'h58, 0, 0, 1, 3);
    add(8'h12, 1, 0, 1, 3);
    add(8'h16, 1, 0, 1, 4, 1, 8'h21);
    add(8'h12, 1, 0, 1, 4);
    add(8'h1C, 1, 0, 1, 5, 1, 8'h61);
    add(8'hF0, 1, 0, 1, 5); add(8'h1C, 1, 0, 1, 5);
    add(8'hF0, 1, 0, 1, 5); add(8'h16, 1, 0, 1, 5);
    add(8'hF0, 1, 0, 1, 5); add(8'h12, 0, 0, 1, 5);
    add(8'h58, 0, 0, 0, 5); add(8'hF0, 0, 0, 0, 5); add(8'h58, 0, 0, 0, 5);
    add(8'hE0, 0, 0, 0, 5); add(8'h75, 0, 0, 0, 6, 1, 8'h00, 1);
    add(8'hE0, 0, 0, 0, 6); add(8'hF0, 0, 0, 0, 6); add(8'h75, 0, 0, 0, 6);
    add(8'hE0, 0, 0, 0, 6); add(8'h14, 0, 1, 0, 6);
    add(8'hE0, 0, 1, 0, 6); add(8'hF0, 0, 1, 0, 6); add(8'h14, 0, 0, 0, 6);
    add(8'h14, 0, 1, 0, 6); add(8'hF0, 0, 1, 0, 6); add(8'h14, 0, 0, 0, 6);
    add(8'hE0, 0, 0, 0, 6); add(8'h12, 0, 0, 0, 6);
    add(8'h29, 0, 0, 0, 7, 1, 8'h20); add(8'hF0, 0, 0, 0, 7); add(8'h29, 0, 0, 0, 7);
    add(8'h5A, 0, 0, 0, 8, 1, 8'h0D); add(8'hF0, 0, 0, 0, 8); add(8'h5A, 0, 0, 0, 8);
    add(8'h66, 0, 0, 0, 9, 1, 8'h08); add(8'hF0, 0, 0, 0, 9); add(8'h66, 0, 0, 0, 9);
    add(8'h45, 0, 0, 0, 10, 1, 8'h30); add(8'hF0, 0, 0, 0, 10); add(8'h45, 0, 0, 0, 10);
    add(8'h12, 1, 0, 0, 10);
    add(8'h45, 1, 0, 0, 11, 1, 8'h29);

    ovf_codes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B};

    bus1.in_data = 8'h00; bus1.in_valid = 1'b0; bus1.out_ready = 1'b0;
    bus2.in_data = 8'h00; bus2.in_valid = 1'b0; bus2.out_ready = 1'b1;
    clrn = 1'b1;
    tick();
    tick();
    clrn = 1'b0;

    check("rst_out_valid", bus1.out_valid, 0);
    check("rst_flags", {shift1, ctrl1, caps1}, 0);
    check("rst_count", cnt1, 0);
    check("rst_level", lvl1, 0);
    check("rst_overflow", ovf1, 0);
    check("rst_ascii", bus1.out_ascii, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      send(vecs[i].data);
      check($sformatf("v%0d_shift", i), shift1, vecs[i].shift);
      check($sformatf("v%0d_ctrl", i), ctrl1, vecs[i].ctrl);
      check($sformatf("v%0d_caps", i), caps1, vecs[i].caps);
      check($sformatf("v%0d_count", i), cnt1, vecs[i].count);
      check($sformatf("v%0d_no_fallthrough", i), bus1.out_valid, 0);
      tick();
      check($sformatf("v%0d_out_valid", i), bus1.out_valid, vecs[i].ev);
      if (vecs[i].ev) begin
        check($sformatf("v%0d_ascii", i), bus1.out_ascii, vecs[i].ascii);
        check($sformatf("v%0d_scan", i), bus1.out_scan, vecs[i].data);
        check($sformatf("v%0d_ext", i), bus1.out_ext, vecs[i].ext);
        check($sformatf("v%0d_repeat", i), bus1.out_repeat, 0);
        pop1();
      end
    end

    // Typematic repeats: filtered instance keeps one event, unfiltered keeps all five.
    bus2.out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) send(8'h1C);
    tick();
    tick();
    check("rep_f1_level", lvl1, 1);
    check("rep_f1_count", cnt1, 1);
    check("rep_f0_level", lvl2, 5);
    check("rep_f0_count", cnt2, 1);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("rep_f0_valid%0d", i), bus2.out_valid, 1);
      check($sformatf("rep_f0_scan%0d", i), bus2.out_scan, 8'h1C);
      check($sformatf("rep_f0_flag%0d", i), bus2.out_repeat, (i != 0));
      check($sformatf("rep_f0_ascii%0d", i), bus2.out_ascii, 8'h61);
      pop2();
    end
    check("rep_f0_empty", bus2.out_valid, 0);
    check("rep_f1_flag", bus1.out_repeat, 0);
    pop1();
    check("rep_f1_empty", bus1.out_valid, 0);

    // Overflow: ten distinct presses into an eight-entry FIFO with no consumer.
    do_reset();
    for (int i = 0; i < 10; i++) send(ovf_codes[i]);
    tick();
    tick();
    check("ovf_level", lvl1, 8);
    check("ovf_flag", ovf1, 1);
    check("ovf_count", cnt1, 10);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("ovf_drain_valid%0d", i), bus1.out_valid, 1);
      check($sformatf("ovf_drain_scan%0d", i), bus1.out_scan, ovf_codes[i]);
      pop1();
    end
    check("ovf_drained_valid", bus1.out_valid, 0);
    check("ovf_drained_level", lvl1, 0);
    check("ovf_sticky", ovf1, 1);
    pop1();
    check("ovf_pop_empty_level", lvl1, 0);

    // Reset between E0 and the next byte must drop the prefix.
    bus2.out_ready = 1'b1;
    send(8'hE0);
    do_reset();
    check("mid_rst_overflow", ovf1, 0);
    send(8'h1C);
    tick();
    check("mid_rst_valid", bus1.out_valid, 1);
    check("mid_rst_scan", bus1.out_scan, 8'h1C);
    check("mid_rst_ext", bus1.out_ext, 0);
    check("mid_rst_ascii", bus1.out_ascii, 8'h61);
    check("mid_rst_count", cnt1, 1);
    pop1();

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
